// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Purpose  : Shared types and the alignment helper for the MEM-stage LSU.
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } access_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  function automatic logic is_misaligned(input access_size_t size, input logic [1:0] addr);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr[0];
      SZ_WORD: return (addr != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_ram_be.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_be
// Purpose  : Single-port synchronous RAM, DEPTH x 32, byte enables, registered read.
// Revision : 1.0 - initial release
// ============================================================================
module data_ram_be #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Read register only moves on a read, so it holds the last load while WB stalls
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu
// Purpose  : MEM stage with sized loads/stores, latency stall and MEM/WB register.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [1:0]      size,
  input  logic            ld_unsigned,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] write_data,
  input  logic [4:0]      rd_in,
  input  logic            reg_write_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_misaligned
);

  localparam int         c_aw       = $clog2(DEPTH);
  localparam bit         c_has_wait = (LATENCY != 0);
  localparam logic [3:0] c_lat_m1   = c_has_wait ? 4'(LATENCY - 1) : 4'd0;

  generate
    if (XLEN != 32) begin : g_bad_xlen
      $error("mem_stage_lsu: only XLEN=32 is supported");
    end
    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
      $error("mem_stage_lsu: LATENCY must be 0..15");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("mem_stage_lsu: DEPTH must be a power of two >= 4");
    end
  endgenerate

  lsu_state_t   r_state, w_state_nxt;
  logic [3:0]   r_cnt, w_cnt_nxt;

  logic         r_op_read, r_op_write, r_op_uns, r_op_regw;
  access_size_t r_op_size;
  logic [31:0]  r_op_alu, r_op_wdata;
  logic [4:0]   r_op_rd;

  logic [31:0]  r_out_data;
  logic [4:0]   r_out_rd;
  logic         r_out_regw, r_out_misal, r_out_is_load, r_out_uns;
  logic [1:0]   r_out_lane;
  access_size_t r_out_size;

  // While waiting the latched op drives the datapath; otherwise the EX inputs do
  logic         w_in_wait, w_accept;
  logic         w_sel_read, w_sel_write, w_sel_uns, w_sel_regw;
  access_size_t w_sel_size;
  logic [31:0]  w_sel_alu, w_sel_wdata;
  logic [4:0]   w_sel_rd;

  assign w_in_wait   = (r_state == WAIT);
  assign w_sel_read  = w_in_wait ? r_op_read  : mem_read;
  assign w_sel_write = w_in_wait ? r_op_write : mem_write;
  assign w_sel_uns   = w_in_wait ? r_op_uns   : ld_unsigned;
  assign w_sel_regw  = w_in_wait ? r_op_regw  : reg_write_in;
  assign w_sel_size  = w_in_wait ? r_op_size  : access_size_t'(size);
  assign w_sel_alu   = w_in_wait ? r_op_alu   : alu_out;
  assign w_sel_wdata = w_in_wait ? r_op_wdata : write_data;
  assign w_sel_rd    = w_in_wait ? r_op_rd    : rd_in;

  logic w_is_mem, w_is_store, w_misal, w_legal_mem, w_to_resp, w_ram_en;

  assign w_is_mem    = w_sel_read | w_sel_write;
  assign w_is_store  = w_sel_write & ~w_sel_read;
  assign w_misal     = w_is_mem & is_misaligned(w_sel_size, w_sel_alu[1:0]);
  assign w_legal_mem = w_is_mem & ~w_misal;

  assign in_ready  = ~rst & ((r_state == IDLE) | ((r_state == RESP) & out_ready));
  assign w_accept  = in_valid & in_ready;
  assign w_to_resp = (w_accept & ~(w_legal_mem & c_has_wait)) | (w_in_wait & (r_cnt == 4'd0));
  assign w_ram_en  = w_to_resp & w_legal_mem;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE, RESP: begin
        if (w_accept) begin
          if (w_legal_mem && c_has_wait) begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = c_lat_m1;
          end else begin
            w_state_nxt = RESP;
          end
        end else if (r_state == RESP && out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = RESP;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_read  <= 1'b0;
      r_op_write <= 1'b0;
      r_op_uns   <= 1'b0;
      r_op_regw  <= 1'b0;
      r_op_size  <= SZ_BYTE;
      r_op_alu   <= '0;
      r_op_wdata <= '0;
      r_op_rd    <= '0;
    end else if (w_accept) begin
      r_op_read  <= mem_read;
      r_op_write <= mem_write;
      r_op_uns   <= ld_unsigned;
      r_op_regw  <= reg_write_in;
      r_op_size  <= access_size_t'(size);
      r_op_alu   <= alu_out;
      r_op_wdata <= write_data;
      r_op_rd    <= rd_in;
    end
  end

  // Store data is replicated across lanes so the byte enables alone pick the target
  logic [31:0] w_ram_wdata, w_ram_rdata;
  logic [3:0]  w_ram_be;

  always_comb begin
    w_ram_wdata = w_sel_wdata;
    w_ram_be    = 4'b1111;
    case (w_sel_size)
      SZ_BYTE: begin
        w_ram_wdata = {4{w_sel_wdata[7:0]}};
        w_ram_be    = 4'b0001 << w_sel_alu[1:0];
      end
      SZ_HALF: begin
        w_ram_wdata = {2{w_sel_wdata[15:0]}};
        w_ram_be    = w_sel_alu[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  data_ram_be #(
    .DEPTH (DEPTH),
    .AW    (c_aw)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_is_store),
    .i_be    (w_ram_be),
    .i_addr  (w_sel_alu[c_aw+1:2]),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data    <= '0;
      r_out_rd      <= '0;
      r_out_regw    <= 1'b0;
      r_out_misal   <= 1'b0;
      r_out_is_load <= 1'b0;
      r_out_uns     <= 1'b0;
      r_out_lane    <= 2'b00;
      r_out_size    <= SZ_BYTE;
    end else if (w_to_resp) begin
      r_out_data    <= w_is_mem ? 32'd0 : w_sel_alu;
      r_out_rd      <= w_sel_rd;
      r_out_regw    <= w_sel_regw & ~w_misal;
      r_out_misal   <= w_misal;
      r_out_is_load <= w_legal_mem & w_sel_read;
      r_out_uns     <= w_sel_uns;
      r_out_lane    <= w_sel_alu[1:0];
      r_out_size    <= w_sel_size;
    end
  end

  // Lane extract sits after the RAM read register, which is stable during a stall
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_load_data;

  always_comb begin
    w_ld_byte   = w_ram_rdata[{r_out_lane, 3'b000} +: 8];
    w_ld_half   = w_ram_rdata[{r_out_lane[1], 4'b0000} +: 16];
    w_load_data = w_ram_rdata;
    case (r_out_size)
      SZ_BYTE: w_load_data = r_out_uns ? {24'd0, w_ld_byte} : {{24{w_ld_byte[7]}}, w_ld_byte};
      SZ_HALF: w_load_data = r_out_uns ? {16'd0, w_ld_half} : {{16{w_ld_half[15]}}, w_ld_half};
      default: ;
    endcase
  end

  assign out_valid      = (r_state == RESP);
  assign out_data       = r_out_is_load ? w_load_data : r_out_data;
  assign out_rd         = r_out_rd;
  assign out_reg_write  = r_out_regw;
  assign out_misaligned = r_out_misal;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_lsu
// Purpose  : Directed plus randomized bench for mem_stage_lsu against a byte-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

  localparam int DEPTH  = 256;
  localparam int LAT    = 2;
  localparam int NBYTES = DEPTH * 4;
  localparam int BUDGET = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, mem_read, mem_write, ld_unsigned, reg_write_in;
  logic [1:0]  size;
  logic [31:0] alu_out, write_data, out_data;
  logic [4:0]  rd_in, out_rd;
  logic        out_valid, out_ready, out_reg_write, out_misaligned;

  mem_stage_lsu #(.DEPTH(DEPTH), .LATENCY(LAT), .XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .size           (size),
    .ld_unsigned    (ld_unsigned),
    .alu_out        (alu_out),
    .write_data     (write_data),
    .rd_in          (rd_in),
    .reg_write_in   (reg_write_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_rd         (out_rd),
    .out_reg_write  (out_reg_write),
    .out_misaligned (out_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd_op;
    logic        wr_op;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        regw;
  } op_t;

  int checks = 0;
  int errors = 0;
  byte unsigned mem_m [NBYTES];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk(input logic r, input logic w, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [4:0] rd, input logic regw);
    op_t o;
    o.rd_op = r; o.wr_op = w; o.sz = sz; o.uns = uns;
    o.addr = addr; o.wdata = wdata; o.rd = rd; o.regw = regw;
    return o;
  endfunction

  function automatic bit m_misal(input op_t o);
    if (!(o.rd_op || o.wr_op)) return 1'b0;
    case (o.sz)
      2'd0:    return 1'b0;
      2'd1:    return (o.addr % 2) != 0;
      2'd2:    return (o.addr % 4) != 0;
      default: return 1'b1;
    endcase
  endfunction

  // Little-endian assembly byte by byte, then arithmetic sign adjustment
  function automatic logic [31:0] m_load(input op_t o);
    int     n = 1 << o.sz;
    int     a = int'(o.addr % NBYTES);
    longint v = 0;
    for (int i = n - 1; i >= 0; i--) v = v * 256 + mem_m[a + i];
    if (!o.uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic m_store(input op_t o);
    int n = 1 << o.sz;
    int a = int'(o.addr % NBYTES);
    for (int i = 0; i < n; i++) mem_m[a + i] = 8'(o.wdata >> (8 * i));
  endtask

  task automatic send(input op_t o);
    int n = 0;
    mem_read = o.rd_op; mem_write = o.wr_op; size = o.sz; ld_unsigned = o.uns;
    alu_out = o.addr; write_data = o.wdata; rd_in = o.rd; reg_write_in = o.regw;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < BUDGET) begin
      @(negedge clk); #1; n++;
    end
    check("accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic expect_resp(input op_t o, input string tag);
    bit mis     = m_misal(o);
    bit is_mem  = o.rd_op || o.wr_op;
    int exp_lat = (is_mem && !mis) ? LAT + 1 : 1;
    int n       = 1;
    @(negedge clk);
    if (exp_lat > 1) check({tag, ".wait_in_ready"}, in_ready, 0);
    while (!out_valid && n < BUDGET) begin
      @(negedge clk); n++;
    end
    check({tag, ".latency"}, n, exp_lat);
    check({tag, ".rd"}, out_rd, o.rd);
    check({tag, ".regw"}, out_reg_write, o.regw && !mis);
    check({tag, ".misal"}, out_misaligned, mis);
    if (mis)           check({tag, ".data"}, out_data, 32'd0);
    else if (!is_mem)  check({tag, ".data"}, out_data, o.addr);
    else if (o.rd_op)  check({tag, ".data"}, out_data, m_load(o));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic run(input op_t o, input string tag);
    send(o);
    expect_resp(o, tag);
    if (o.wr_op && !o.rd_op && !m_misal(o)) m_store(o);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o, o2;
    int  kind, hold;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; size = 2'd0; ld_unsigned = 1'b0;
    alu_out = '0; write_data = '0; rd_in = '0; reg_write_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.out_valid", out_valid, 0);
    check("rst.out_data", out_data, 0);
    check("rst.out_rd", out_rd, 0);
    check("rst.out_reg_write", out_reg_write, 0);
    check("rst.out_misaligned", out_misaligned, 0);
    check("rst.in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int w = 0; w < 16; w++) run(mk(0, 1, 2'd2, 0, 32'(w * 4), $urandom, 5'd0, 0), "init");

    run(mk(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 5'd0, 0), "st_word");
    run(mk(1, 0, 2'd2, 0, 32'h10, 32'h0, 5'd3, 1), "ld_word");

    run(mk(0, 1, 2'd2, 0, 32'h10, 32'h11223344, 5'd0, 0), "st_base");
    run(mk(0, 1, 2'd0, 0, 32'h13, 32'hFFFFFF80, 5'd0, 0), "st_byte");
    run(mk(1, 0, 2'd0, 0, 32'h13, 32'h0, 5'd4, 1), "ld_byte_s");
    run(mk(1, 0, 2'd0, 1, 32'h13, 32'h0, 5'd4, 1), "ld_byte_u");
    run(mk(1, 0, 2'd2, 0, 32'h10, 32'h0, 5'd4, 1), "ld_merged");
    run(mk(1, 0, 2'd1, 0, 32'h12, 32'h0, 5'd5, 1), "ld_half_s");

    run(mk(1, 0, 2'd1, 0, 32'h11, 32'h0, 5'd6, 1), "mis_ld_half");
    run(mk(0, 1, 2'd2, 0, 32'h22, 32'hBAD0BAD0, 5'd6, 1), "mis_st_word");
    run(mk(1, 0, 2'd3, 0, 32'h20, 32'h0, 5'd6, 1), "mis_rsvd");
    run(mk(1, 0, 2'd2, 0, 32'h20, 32'h0, 5'd6, 1), "word8_intact");

    o = mk(0, 0, 2'd2, 0, 32'h12345678, 32'h0, 5'd7, 1);
    send(o);
    expect_resp(o, "hold");
    for (int i = 0; i < 4; i++) begin
      check("hold.valid", out_valid, 1);
      check("hold.data", out_data, 32'h12345678);
      check("hold.rd", out_rd, 7);
      check("hold.in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("release.in_ready", in_ready, 1);
    o2 = mk(0, 0, 2'd0, 0, 32'hCAFEF00D, 32'h0, 5'd9, 0);
    send(o2);
    expect_resp(o2, "b2b");
    drain();

    run(mk(0, 1, 2'd2, 0, 32'h400, 32'h0BADF00D, 5'd0, 0), "alias_st");
    run(mk(1, 0, 2'd2, 0, 32'h0, 32'h0, 5'd1, 1), "alias_ld");

    o = mk(0, 1, 2'd2, 0, 32'h30, 32'hA5A55A5A, 5'd0, 0);
    send(o);
    @(negedge clk);
    check("rstwait.pre_in_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    check("rstwait.out_valid", out_valid, 0);
    check("rstwait.in_ready", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(mk(1, 0, 2'd2, 0, 32'h30, 32'h0, 5'd2, 1), "rstwait.ld_old");

    for (int i = 0; i < 200; i++) begin
      kind    = int'($urandom_range(0, 9));
      o.rd_op = (kind < 4) || (kind == 9);
      o.wr_op = (kind >= 4 && kind < 8) || (kind == 9);
      o.sz    = 2'($urandom_range(0, 3));
      o.uns   = 1'($urandom_range(0, 1));
      o.addr  = (o.rd_op || o.wr_op) ? ($urandom & 32'hFFFFFC3F) : $urandom;
      o.wdata = $urandom;
      o.rd    = 5'($urandom_range(0, 31));
      o.regw  = 1'($urandom_range(0, 1));
      send(o);
      expect_resp(o, "rand");
      if (o.wr_op && !o.rd_op && !m_misal(o)) m_store(o);
      hold = int'($urandom_range(0, 2));
      repeat (hold) @(negedge clk);
      check("rand.hold_valid", out_valid, 1);
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
